// File: rtl/axi_lite_arbiter_pkg.sv
// Shared types and constants for the two-master AXI-Lite arbiter.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin tie-break in IDLE).
package axi_lite_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned STRB_W_DEF = DATA_W_DEF / 8;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IFU_RD = 3'd1,
        ST_IFU_WR = 3'd2,
        ST_LSU_RD = 3'd3,
        ST_LSU_WR = 3'd4
    } arb_state_e;

    typedef enum logic {
        MST_IFU = 1'b0,
        MST_LSU = 1'b1
    } arb_master_e;

    function automatic logic is_read_state(arb_state_e s);
        return (s == ST_IFU_RD) || (s == ST_LSU_RD);
    endfunction

    function automatic logic is_write_state(arb_state_e s);
        return (s == ST_IFU_WR) || (s == ST_LSU_WR);
    endfunction

    function automatic logic is_lsu_state(arb_state_e s);
        return (s == ST_LSU_RD) || (s == ST_LSU_WR);
    endfunction

endpackage

// File: rtl/axi_lite_arb_grant.sv
// Grant state machine: decides which master owns the SRAM port and when
// the grant is released. Optional build macro: ARB_ROUND_ROBIN_EN.
module axi_lite_arb_grant
    import axi_lite_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       ifu_rd_req_i,
    input  logic       ifu_wr_req_i,
    input  logic       lsu_rd_req_i,
    input  logic       lsu_wr_req_i,
    input  logic       rd_done_i,
    input  logic       wr_done_i,
    output arb_state_e state_o
);

    arb_state_e state_q, state_d;
    logic       ifu_req;
    logic       lsu_req;
    logic       pick_lsu;

    assign ifu_req = ifu_rd_req_i | ifu_wr_req_i;
    assign lsu_req = lsu_rd_req_i | lsu_wr_req_i;

`ifdef ARB_ROUND_ROBIN_EN
    arb_master_e last_q, last_d;

    // Tie-break: on a tie, hand the port to whichever master did not go last
    always_comb begin
        pick_lsu = lsu_req & (~ifu_req | (last_q == MST_IFU));
    end

    // Remember the master granted out of IDLE
    always_comb begin
        last_d = last_q;
        if (state_q == ST_IDLE) begin
            if (pick_lsu) begin
                last_d = MST_LSU;
            end else if (ifu_req) begin
                last_d = MST_IFU;
            end
        end
    end

    // Round-robin pointer register, restarts pointing at IFU
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            last_q <= MST_IFU;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Tie-break: LSU always beats IFU
    always_comb begin
        pick_lsu = lsu_req;
    end
`endif

    // Next-state: grant from IDLE (read beats write), release on the handshake
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_lsu) begin
                    state_d = lsu_rd_req_i ? ST_LSU_RD : ST_LSU_WR;
                end else if (ifu_req) begin
                    state_d = ifu_rd_req_i ? ST_IFU_RD : ST_IFU_WR;
                end
            end
            ST_IFU_RD, ST_LSU_RD: begin
                if (rd_done_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IFU_WR, ST_LSU_WR: begin
                if (wr_done_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master (IFU, LSU) to one-slave (SRAM) AXI-Lite arbiter. One transaction
// is in flight at a time; the owner's channels are wired straight through.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin tie-break in IDLE).
module axi_lite_arbiter
    import axi_lite_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned STRB_W = STRB_W_DEF
) (
    input  logic              CLK,
    input  logic              RESETN,

    input  logic              IFU_AWVALID,
    input  logic [ADDR_W-1:0] IFU_AWADDR,
    output logic              IFU_AWREADY,
    input  logic              IFU_WVALID,
    input  logic [DATA_W-1:0] IFU_WDATA,
    input  logic [STRB_W-1:0] IFU_WSTRB,
    output logic              IFU_WREADY,
    output logic [1:0]        IFU_BRESP,
    output logic              IFU_BVALID,
    input  logic              IFU_BREADY,
    input  logic              IFU_ARVALID,
    input  logic [ADDR_W-1:0] IFU_ARADDR,
    output logic              IFU_ARREADY,
    output logic [DATA_W-1:0] IFU_RDATA,
    output logic [1:0]        IFU_RRESP,
    output logic              IFU_RVALID,
    input  logic              IFU_RREADY,

    input  logic              LSU_AWVALID,
    input  logic [ADDR_W-1:0] LSU_AWADDR,
    output logic              LSU_AWREADY,
    input  logic              LSU_WVALID,
    input  logic [DATA_W-1:0] LSU_WDATA,
    input  logic [STRB_W-1:0] LSU_WSTRB,
    output logic              LSU_WREADY,
    output logic [1:0]        LSU_BRESP,
    output logic              LSU_BVALID,
    input  logic              LSU_BREADY,
    input  logic              LSU_ARVALID,
    input  logic [ADDR_W-1:0] LSU_ARADDR,
    output logic              LSU_ARREADY,
    output logic [DATA_W-1:0] LSU_RDATA,
    output logic [1:0]        LSU_RRESP,
    output logic              LSU_RVALID,
    input  logic              LSU_RREADY,

    output logic              SRAM_AWVALID,
    output logic [ADDR_W-1:0] SRAM_AWADDR,
    input  logic              SRAM_AWREADY,
    output logic              SRAM_WVALID,
    output logic [DATA_W-1:0] SRAM_WDATA,
    output logic [STRB_W-1:0] SRAM_WSTRB,
    input  logic              SRAM_WREADY,
    input  logic [1:0]        SRAM_BRESP,
    input  logic              SRAM_BVALID,
    output logic              SRAM_BREADY,
    output logic              SRAM_ARVALID,
    output logic [ADDR_W-1:0] SRAM_ARADDR,
    input  logic              SRAM_ARREADY,
    input  logic [DATA_W-1:0] SRAM_RDATA,
    input  logic [1:0]        SRAM_RRESP,
    input  logic              SRAM_RVALID,
    output logic              SRAM_RREADY
);

    arb_state_e state;
    logic       sel_lsu;
    logic       rd_act;
    logic       wr_act;

    // Request side of the owning master
    logic              m_awvalid;
    logic [ADDR_W-1:0] m_awaddr;
    logic              m_wvalid;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;
    logic              m_bready;
    logic              m_arvalid;
    logic [ADDR_W-1:0] m_araddr;
    logic              m_rready;

    // Response side destined for the owning master
    logic              s_awready;
    logic              s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_arready;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;

    axi_lite_arb_grant u_grant (
        .clk_i        (CLK),
        .rstn_i       (RESETN),
        .ifu_rd_req_i (IFU_ARVALID),
        .ifu_wr_req_i (IFU_AWVALID | IFU_WVALID),
        .lsu_rd_req_i (LSU_ARVALID),
        .lsu_wr_req_i (LSU_AWVALID | LSU_WVALID),
        .rd_done_i    (SRAM_RVALID & SRAM_RREADY),
        .wr_done_i    (SRAM_BVALID & SRAM_BREADY),
        .state_o      (state)
    );

    assign sel_lsu = is_lsu_state(state);
    assign rd_act  = is_read_state(state);
    assign wr_act  = is_write_state(state);

    // Pick the request-side signals of whichever master owns the grant
    always_comb begin
        if (sel_lsu) begin
            m_awvalid = LSU_AWVALID;
            m_awaddr  = LSU_AWADDR;
            m_wvalid  = LSU_WVALID;
            m_wdata   = LSU_WDATA;
            m_wstrb   = LSU_WSTRB;
            m_bready  = LSU_BREADY;
            m_arvalid = LSU_ARVALID;
            m_araddr  = LSU_ARADDR;
            m_rready  = LSU_RREADY;
        end else begin
            m_awvalid = IFU_AWVALID;
            m_awaddr  = IFU_AWADDR;
            m_wvalid  = IFU_WVALID;
            m_wdata   = IFU_WDATA;
            m_wstrb   = IFU_WSTRB;
            m_bready  = IFU_BREADY;
            m_arvalid = IFU_ARVALID;
            m_araddr  = IFU_ARADDR;
            m_rready  = IFU_RREADY;
        end
    end

    // Open only the channels belonging to the active transaction kind
    always_comb begin
        SRAM_AWVALID = 1'b0;
        SRAM_AWADDR  = '0;
        SRAM_WVALID  = 1'b0;
        SRAM_WDATA   = '0;
        SRAM_WSTRB   = '0;
        SRAM_BREADY  = 1'b0;
        SRAM_ARVALID = 1'b0;
        SRAM_ARADDR  = '0;
        SRAM_RREADY  = 1'b0;
        s_awready    = 1'b0;
        s_wready     = 1'b0;
        s_bresp      = RESP_OKAY;
        s_bvalid     = 1'b0;
        s_arready    = 1'b0;
        s_rdata      = '0;
        s_rresp      = RESP_OKAY;
        s_rvalid     = 1'b0;
        if (rd_act) begin
            SRAM_ARVALID = m_arvalid;
            SRAM_ARADDR  = m_araddr;
            SRAM_RREADY  = m_rready;
            s_arready    = SRAM_ARREADY;
            s_rdata      = SRAM_RDATA;
            s_rresp      = SRAM_RRESP;
            s_rvalid     = SRAM_RVALID;
        end else if (wr_act) begin
            SRAM_AWVALID = m_awvalid;
            SRAM_AWADDR  = m_awaddr;
            SRAM_WVALID  = m_wvalid;
            SRAM_WDATA   = m_wdata;
            SRAM_WSTRB   = m_wstrb;
            SRAM_BREADY  = m_bready;
            s_awready    = SRAM_AWREADY;
            s_wready     = SRAM_WREADY;
            s_bresp      = SRAM_BRESP;
            s_bvalid     = SRAM_BVALID;
        end
    end

    // Return responses to the owner only; the other master sees all zeros
    always_comb begin
        IFU_AWREADY = 1'b0;
        IFU_WREADY  = 1'b0;
        IFU_BRESP   = RESP_OKAY;
        IFU_BVALID  = 1'b0;
        IFU_ARREADY = 1'b0;
        IFU_RDATA   = '0;
        IFU_RRESP   = RESP_OKAY;
        IFU_RVALID  = 1'b0;
        LSU_AWREADY = 1'b0;
        LSU_WREADY  = 1'b0;
        LSU_BRESP   = RESP_OKAY;
        LSU_BVALID  = 1'b0;
        LSU_ARREADY = 1'b0;
        LSU_RDATA   = '0;
        LSU_RRESP   = RESP_OKAY;
        LSU_RVALID  = 1'b0;
        if (sel_lsu) begin
            LSU_AWREADY = s_awready;
            LSU_WREADY  = s_wready;
            LSU_BRESP   = s_bresp;
            LSU_BVALID  = s_bvalid;
            LSU_ARREADY = s_arready;
            LSU_RDATA   = s_rdata;
            LSU_RRESP   = s_rresp;
            LSU_RVALID  = s_rvalid;
        end else begin
            IFU_AWREADY = s_awready;
            IFU_WREADY  = s_wready;
            IFU_BRESP   = s_bresp;
            IFU_BVALID  = s_bvalid;
            IFU_ARREADY = s_arready;
            IFU_RDATA   = s_rdata;
            IFU_RRESP   = s_rresp;
            IFU_RVALID  = s_rvalid;
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Self-checking bench for axi_lite_arbiter: grant table, directed corner
// sequences and random traffic against a transaction-level owner model.
// Honours ARB_ROUND_ROBIN_EN when defined for the build.
module tb_axi_lite_arbiter;

    typedef struct packed {
        logic        awvalid;
        logic [31:0] awaddr;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        bready;
        logic        arvalid;
        logic [31:0] araddr;
        logic        rready;
    } mst_in_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rvalid;
    } slv_in_t;

    typedef struct {
        logic        ia, iw, iwv, la, law, lwv;
        logic        e_arv;
        logic [31:0] e_araddr;
        logic        e_awv, e_wv;
        logic [31:0] e_awaddr;
    } vec_t;

    logic    CLK = 1'b0;
    logic    RESETN;
    mst_in_t ifu, lsu;
    slv_in_t sin;

    logic        IFU_AWREADY, IFU_WREADY, IFU_BVALID, IFU_ARREADY, IFU_RVALID;
    logic [1:0]  IFU_BRESP, IFU_RRESP;
    logic [31:0] IFU_RDATA;
    logic        LSU_AWREADY, LSU_WREADY, LSU_BVALID, LSU_ARREADY, LSU_RVALID;
    logic [1:0]  LSU_BRESP, LSU_RRESP;
    logic [31:0] LSU_RDATA;
    logic        SRAM_AWVALID, SRAM_WVALID, SRAM_BREADY, SRAM_ARVALID, SRAM_RREADY;
    logic [31:0] SRAM_AWADDR, SRAM_WDATA, SRAM_ARADDR;
    logic [3:0]  SRAM_WSTRB;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the SRAM port (0 none, 1 IFU, 2 LSU) and whether it reads
    int owner   = 0;
    bit own_rd  = 1'b0;
    bit last_lsu = 1'b0;

    always #5 CLK = ~CLK;

    axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32), .STRB_W(4)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .IFU_AWVALID(ifu.awvalid), .IFU_AWADDR(ifu.awaddr), .IFU_AWREADY(IFU_AWREADY),
        .IFU_WVALID(ifu.wvalid), .IFU_WDATA(ifu.wdata), .IFU_WSTRB(ifu.wstrb), .IFU_WREADY(IFU_WREADY),
        .IFU_BRESP(IFU_BRESP), .IFU_BVALID(IFU_BVALID), .IFU_BREADY(ifu.bready),
        .IFU_ARVALID(ifu.arvalid), .IFU_ARADDR(ifu.araddr), .IFU_ARREADY(IFU_ARREADY),
        .IFU_RDATA(IFU_RDATA), .IFU_RRESP(IFU_RRESP), .IFU_RVALID(IFU_RVALID), .IFU_RREADY(ifu.rready),
        .LSU_AWVALID(lsu.awvalid), .LSU_AWADDR(lsu.awaddr), .LSU_AWREADY(LSU_AWREADY),
        .LSU_WVALID(lsu.wvalid), .LSU_WDATA(lsu.wdata), .LSU_WSTRB(lsu.wstrb), .LSU_WREADY(LSU_WREADY),
        .LSU_BRESP(LSU_BRESP), .LSU_BVALID(LSU_BVALID), .LSU_BREADY(lsu.bready),
        .LSU_ARVALID(lsu.arvalid), .LSU_ARADDR(lsu.araddr), .LSU_ARREADY(LSU_ARREADY),
        .LSU_RDATA(LSU_RDATA), .LSU_RRESP(LSU_RRESP), .LSU_RVALID(LSU_RVALID), .LSU_RREADY(lsu.rready),
        .SRAM_AWVALID(SRAM_AWVALID), .SRAM_AWADDR(SRAM_AWADDR), .SRAM_AWREADY(sin.awready),
        .SRAM_WVALID(SRAM_WVALID), .SRAM_WDATA(SRAM_WDATA), .SRAM_WSTRB(SRAM_WSTRB), .SRAM_WREADY(sin.wready),
        .SRAM_BRESP(sin.bresp), .SRAM_BVALID(sin.bvalid), .SRAM_BREADY(SRAM_BREADY),
        .SRAM_ARVALID(SRAM_ARVALID), .SRAM_ARADDR(SRAM_ARADDR), .SRAM_ARREADY(sin.arready),
        .SRAM_RDATA(sin.rdata), .SRAM_RRESP(sin.rresp), .SRAM_RVALID(sin.rvalid), .SRAM_RREADY(SRAM_RREADY)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // The owner's request channel of its transaction kind reaches SRAM, and
    // SRAM's reply on that channel reaches the owner; everything else is zero.
    task automatic model_check();
        mst_in_t        m;
        logic [40:0]    resp, e_ifu, e_lsu;
        logic [104:0]   e_sram;
        e_ifu = '0; e_lsu = '0; e_sram = '0; resp = '0;
        if (owner != 0) begin
            m = (owner == 2) ? lsu : ifu;
            if (own_rd) begin
                e_sram = {1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, m.arvalid, m.araddr, m.rready};
                resp   = {1'b0, 1'b0, 2'b00, 1'b0, sin.arready, sin.rdata, sin.rresp, sin.rvalid};
            end else begin
                e_sram = {m.awvalid, m.awaddr, m.wvalid, m.wdata, m.wstrb, m.bready, 1'b0, 32'h0, 1'b0};
                resp   = {sin.awready, sin.wready, sin.bresp, sin.bvalid, 1'b0, 32'h0, 2'b00, 1'b0};
            end
            if (owner == 2) e_lsu = resp; else e_ifu = resp;
        end
        chk("ifu_outputs", 128'({IFU_AWREADY, IFU_WREADY, IFU_BRESP, IFU_BVALID, IFU_ARREADY,
                                 IFU_RDATA, IFU_RRESP, IFU_RVALID}), 128'(e_ifu));
        chk("lsu_outputs", 128'({LSU_AWREADY, LSU_WREADY, LSU_BRESP, LSU_BVALID, LSU_ARREADY,
                                 LSU_RDATA, LSU_RRESP, LSU_RVALID}), 128'(e_lsu));
        chk("sram_outputs", 128'({SRAM_AWVALID, SRAM_AWADDR, SRAM_WVALID, SRAM_WDATA, SRAM_WSTRB,
                                  SRAM_BREADY, SRAM_ARVALID, SRAM_ARADDR, SRAM_RREADY}), 128'(e_sram));
    endtask

    // Ownership update seen at a clock edge
    task automatic model_edge();
        bit ireq, lreq;
        int win;
        ireq = ifu.arvalid | ifu.awvalid | ifu.wvalid;
        lreq = lsu.arvalid | lsu.awvalid | lsu.wvalid;
        if (!RESETN) begin
            owner = 0; last_lsu = 1'b0;
        end else if (owner == 0) begin
            win = 0;
            if (ireq && lreq) begin
`ifdef ARB_ROUND_ROBIN_EN
                win = last_lsu ? 1 : 2;
`else
                win = 2;
`endif
            end else if (lreq) win = 2;
            else if (ireq) win = 1;
            if (win != 0) begin
                owner    = win;
                own_rd   = (win == 2) ? lsu.arvalid : ifu.arvalid;
                last_lsu = (win == 2);
            end
        end else begin
            if (own_rd && sin.rvalid && ((owner == 2) ? lsu.rready : ifu.rready)) owner = 0;
            if (!own_rd && sin.bvalid && ((owner == 2) ? lsu.bready : ifu.bready)) owner = 0;
        end
    endtask

    // One clock: check current outputs, advance model and DUT, settle
    task automatic step();
        #1;
        model_check();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ifu = '0; lsu = '0; sin = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RESETN = 1'b0;
        step();
        RESETN = 1'b1;
    endtask

    function automatic mst_in_t rand_m();
        mst_in_t m;
        m.awvalid = ($urandom_range(0, 5) == 0);
        m.awaddr  = $urandom;
        m.wvalid  = ($urandom_range(0, 5) == 0);
        m.wdata   = $urandom;
        m.wstrb   = 4'($urandom);
        m.bready  = ($urandom_range(0, 2) != 0);
        m.arvalid = ($urandom_range(0, 3) == 0);
        m.araddr  = $urandom;
        m.rready  = ($urandom_range(0, 2) != 0);
        return m;
    endfunction

    vec_t vecs[10];

    initial begin
        RESETN = 1'b0;
        clear_inputs();

        // ---- grant table: requests in IDLE, forwarded next cycle ----
        vecs[0] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,32'h0,        1'b0,1'b0,32'h0};
        vecs[1] = '{1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b1,32'h1000_0000,1'b0,1'b0,32'h0};
        vecs[2] = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 1'b0,32'h0,        1'b1,1'b0,32'h1100_0000};
        vecs[3] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 1'b0,32'h0,        1'b0,1'b1,32'h1100_0000};
        vecs[4] = '{1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0, 1'b1,32'h1000_0000,1'b0,1'b0,32'h0};
        vecs[5] = '{1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1, 1'b0,32'h0,        1'b1,1'b1,32'h2100_0000};
        vecs[6] = '{1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0, 1'b1,32'h2000_0000,1'b0,1'b0,32'h0};
        vecs[7] = '{1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1, 1'b0,32'h0,        1'b0,1'b1,32'h2100_0000};
        vecs[8] = '{1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0, 1'b1,32'h2000_0000,1'b0,1'b0,32'h0};
        vecs[9] = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0, 1'b0,32'h0,        1'b1,1'b1,32'h1100_0000};
        for (int i = 0; i < 10; i++) begin
            do_reset();
            ifu.araddr = 32'h1000_0000; ifu.awaddr = 32'h1100_0000;
            lsu.araddr = 32'h2000_0000; lsu.awaddr = 32'h2100_0000;
            ifu.arvalid = vecs[i].ia; ifu.awvalid = vecs[i].iw; ifu.wvalid = vecs[i].iwv;
            lsu.arvalid = vecs[i].la; lsu.awvalid = vecs[i].law; lsu.wvalid = vecs[i].lwv;
            step();
            chk($sformatf("vec%0d_grant", i),
                128'({SRAM_ARVALID, SRAM_ARADDR, SRAM_AWVALID, SRAM_WVALID, SRAM_AWADDR}),
                128'({vecs[i].e_arv, vecs[i].e_araddr, vecs[i].e_awv, vecs[i].e_wv, vecs[i].e_awaddr}));
            clear_inputs();
            ifu.rready = 1'b1; ifu.bready = 1'b1; lsu.rready = 1'b1; lsu.bready = 1'b1;
            sin.rvalid = 1'b1; sin.bvalid = 1'b1;
            step();
            clear_inputs();
            step();
        end

        // ---- IFU fetch of one instruction word ----
        do_reset();
        ifu.arvalid = 1'b1; ifu.araddr = 32'h8000_0000; ifu.rready = 1'b1;
        #1 chk("fetch_idle_quiet", 128'(SRAM_ARVALID), 128'(0));
        step();
        chk("fetch_araddr", 128'({SRAM_ARVALID, SRAM_ARADDR}), 128'({1'b1, 32'h8000_0000}));
        sin.arready = 1'b1;
        step();
        ifu.arvalid = 1'b0; sin.arready = 1'b0;
        sin.rvalid = 1'b1; sin.rdata = 32'h0000_0413;
        #1 chk("fetch_rdata", 128'({IFU_RVALID, IFU_RDATA}), 128'({1'b1, 32'h0000_0413}));
        step();
        sin = '0;
        #1 chk("fetch_back_idle", 128'({SRAM_RREADY, IFU_RDATA}), 128'(0));
        step();

        // ---- simultaneous reads: LSU first, IFU after one IDLE cycle ----
        do_reset();
        ifu.arvalid = 1'b1; ifu.araddr = 32'h0000_1110; ifu.rready = 1'b1;
        lsu.arvalid = 1'b1; lsu.araddr = 32'h0000_2220; lsu.rready = 1'b1;
        step();
        chk("tie_lsu_first", 128'({SRAM_ARADDR, IFU_ARREADY}), 128'({32'h0000_2220, 1'b0}));
        sin.arready = 1'b1; sin.rvalid = 1'b1; lsu.arvalid = 1'b0;
        step();
        sin = '0;
        #1 chk("tie_idle_gap", 128'(SRAM_ARVALID), 128'(0));
        step();
        sin.arready = 1'b1;
        #1 chk("tie_ifu_second", 128'({SRAM_ARADDR, IFU_ARREADY}), 128'({32'h0000_1110, 1'b1}));
        ifu.arvalid = 1'b0; sin.rvalid = 1'b1;
        step();
        clear_inputs();
        step();

        // ---- LSU write routed only to LSU ----
        do_reset();
        lsu.awvalid = 1'b1; lsu.awaddr = 32'h8000_1000; lsu.wvalid = 1'b1;
        lsu.wdata = 32'hDEAD_BEEF; lsu.wstrb = 4'b0011; lsu.bready = 1'b1; ifu.bready = 1'b1;
        step();
        chk("wr_fields", 128'({SRAM_AWVALID, SRAM_AWADDR, SRAM_WVALID, SRAM_WDATA, SRAM_WSTRB}),
            128'({1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011}));
        lsu.awvalid = 1'b0; lsu.wvalid = 1'b0; sin.bvalid = 1'b1;
        #1 chk("wr_bvalid_routing", 128'({LSU_BVALID, IFU_BVALID}), 128'({1'b1, 1'b0}));
        step();
        clear_inputs();
        step();

        // ---- IFU held off while LSU read waits on SRAM ----
        do_reset();
        lsu.arvalid = 1'b1; lsu.araddr = 32'h3000_0040; lsu.rready = 1'b1;
        step();
        lsu.arvalid = 1'b0; sin.arready = 1'b1;
        ifu.arvalid = 1'b1; ifu.araddr = 32'h0000_1234; ifu.rready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1 chk($sformatf("hold_c%0d", c), 128'({IFU_ARREADY, SRAM_ARADDR}), 128'({1'b0, 32'h3000_0040}));
            step();
        end
        sin.rvalid = 1'b1;
        step();
        sin.rvalid = 1'b0;
        step();
        #1 chk("hold_ifu_kept", 128'({SRAM_ARVALID, SRAM_ARADDR}), 128'({1'b1, 32'h0000_1234}));
        ifu.arvalid = 1'b0; sin.rvalid = 1'b1;
        step();
        clear_inputs();
        step();

        // ---- reset in the middle of an IFU read ----
        do_reset();
        ifu.arvalid = 1'b1; ifu.araddr = 32'h8000_0010; ifu.rready = 1'b1;
        step();
        RESETN = 1'b0;
        step();
        RESETN = 1'b1; ifu.arvalid = 1'b0;
        sin.rvalid = 1'b1; sin.rdata = 32'hCAFE_0001; sin.arready = 1'b1;
        #1 chk("rst_abandon", 128'({IFU_RVALID, IFU_RDATA, IFU_ARREADY, SRAM_ARVALID, SRAM_RREADY}), 128'(0));
        step();
        clear_inputs();
        step();

        // ---- LSU read and write together: read first ----
        do_reset();
        lsu.arvalid = 1'b1; lsu.araddr = 32'h4000_0000; lsu.rready = 1'b1;
        lsu.awvalid = 1'b1; lsu.awaddr = 32'h4000_0100; lsu.wvalid = 1'b1; lsu.bready = 1'b1;
        step();
        chk("rw_read_first", 128'({SRAM_ARVALID, SRAM_AWVALID, SRAM_WVALID}), 128'({1'b1, 1'b0, 1'b0}));
        lsu.arvalid = 1'b0; sin.rvalid = 1'b1;
        step();
        sin.rvalid = 1'b0;
        step();
        chk("rw_write_after", 128'({SRAM_AWVALID, SRAM_AWADDR, SRAM_ARVALID}), 128'({1'b1, 32'h4000_0100, 1'b0}));
        lsu.awvalid = 1'b0; lsu.wvalid = 1'b0; sin.bvalid = 1'b1;
        step();
        clear_inputs();
        step();

        // ---- random traffic against the owner model ----
        for (int c = 0; c < 3000; c++) begin
            RESETN = ($urandom_range(0, 99) != 0);
            ifu = rand_m();
            lsu = rand_m();
            sin.awready = 1'($urandom); sin.wready = 1'($urandom);
            sin.bresp   = 2'($urandom); sin.bvalid = ($urandom_range(0, 3) == 0);
            sin.arready = 1'($urandom); sin.rdata  = $urandom;
            sin.rresp   = 2'($urandom); sin.rvalid = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width; STRB_W, default DATA_W/8 (4), write-strobe width.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 CLK  in  1  clock; all state updates on its rising edge.
REQ-004 RESETN  in  1  synchronous active-low reset.
REQ-005 Each master port set is prefixed IFU_ or LSU_ and is identical: AWVALID in 1, AWADDR in ADDR_W, AWREADY out 1.
REQ-006 Same master port set continues: WVALID in 1, WDATA in DATA_W, WSTRB in STRB_W, WREADY out 1.
REQ-007 Same master port set continues: BRESP out 2, BVALID out 1, BREADY in 1.
REQ-008 Same master port set continues: ARVALID in 1, ARADDR in ADDR_W, ARREADY out 1.
REQ-009 Same master port set continues: RDATA out DATA_W, RRESP out 2, RVALID out 1, RREADY in 1.
REQ-010 Slave port set is prefixed SRAM_ and mirrors the master set with every direction inverted (AW, W, B, AR, R channels).

Function
REQ-011 FSM states: IDLE, IFU_RD, IFU_WR, LSU_RD, LSU_WR; state is registered.
REQ-012 Master read request: ARVALID=1. Master write request: AWVALID=1 or WVALID=1.
REQ-013 In IDLE, if LSU requests, grant LSU; otherwise, if IFU requests, grant IFU; otherwise stay in IDLE.
REQ-014 Within the granted master, a read request wins over a simultaneous write request; the next state is the matching *_RD or *_WR state.
REQ-015 In IDLE, all SRAM_*VALID and SRAM_*READY outputs are 0, all master READY/VALID outputs are 0, and all data/address/strb/resp outputs are 0.
REQ-016 Read states: connect the granted master's AR and R channels to SRAM_AR and SRAM_R combinationally; tie the SRAM AW/W/BREADY outputs to 0.
REQ-017 Write states: connect the granted master's AW, W and B channels to SRAM combinationally; tie SRAM_ARVALID and SRAM_RREADY to 0.
REQ-018 The non-granted master always sees READY=0, VALID=0 and zero data; its pending requests are held, not dropped.
REQ-019 A read grant ends in the cycle of the SRAM_RVALID & SRAM_RREADY handshake; the next state is IDLE.
REQ-020 A write grant ends in the cycle of the SRAM_BVALID & SRAM_BREADY handshake; the next state is IDLE.
REQ-021 Latency: a request seen in IDLE at cycle n is forwarded to SRAM at n+1. Back-to-back transactions are separated by at least one IDLE cycle.
REQ-022 A grant is never revoked before completion, whatever the other master's requests do.
REQ-023 The arbiter has no timeout; a slave that never responds holds the grant indefinitely.

Reset
REQ-024 When RESETN=0 at a clock edge, the state becomes IDLE (and the round-robin pointer, if built, becomes IFU); REQ-015 outputs apply from the next cycle.
REQ-025 Reset during an active grant abandons the transaction with no completion response generated.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN selects the IDLE tie-break rule.
REQ-027 With ARB_ROUND_ROBIN_EN defined, a one-bit pointer records the last granted master; on a tie in IDLE, the other master is granted.
REQ-028 Without ARB_ROUND_ROBIN_EN, the fixed LSU-over-IFU priority of REQ-013 applies and no pointer register exists.

Structure
REQ-029 A shared package holds the state enum, the default ADDR_W/DATA_W/STRB_W constants, and the RESP_OKAY=2'b00 constant.
REQ-030 The state register and grant logic live in one sub-module, axi_lite_arb_grant; the channel muxing stays in the top module.

Verification
REQ-031 IFU ARVALID=1, ARADDR=0x8000_0000; SRAM returns RDATA=0x0000_0413 -> SRAM_ARADDR=0x8000_0000 one cycle later; IFU_RDATA=0x0000_0413; state returns to IDLE.
REQ-032 IFU and LSU ARVALID rise in the same IDLE cycle -> LSU granted first; IFU forwarded only after the LSU R handshake plus one IDLE cycle (round-robin build: alternation on repeated ties).
REQ-033 LSU write: AWADDR=0x8000_1000, WDATA=0xDEAD_BEEF, WSTRB=4'b0011 -> SRAM sees identical values; BVALID routed to LSU only; IFU_BVALID stays 0.
REQ-034 While LSU_RD is waiting on SRAM_RVALID, IFU asserts ARVALID for 5 cycles -> IFU_ARREADY stays 0 and SRAM_ARADDR is unchanged.
REQ-035 RESETN=0 for one cycle in IFU_RD before RVALID -> next cycle state IDLE and all outputs 0; a later SRAM_RVALID is not forwarded.
REQ-036 LSU asserts ARVALID and AWVALID together -> read is serviced first; the write is serviced after the read completes.
